// File: rtl/waveform_decimator_if.sv
// Sample stream bundle: one beat of packed channel data plus its event lines and timestamp.
interface waveform_decimator_if #(
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned TimestampWidth = 64
) ();
   logic [DataWidth-1:0]      data;
   logic                      valid;
   logic [7:0]                triggers;
   logic [TimestampWidth-1:0] timestamp;

   modport master (output data, output valid, output triggers, output timestamp);
   modport slave  (input data, input valid, input triggers, input timestamp);
endinterface

// File: rtl/waveform_decimator.sv
// Boxcar-averaging decimator: sums N valid samples per channel, shifts, saturates and emits
// one registered beat per window together with OR-ed triggers and the window's first timestamp.
module waveform_decimator #(
   parameter int unsigned Channels       = 4,
   parameter int unsigned SampleWidth    = 16,
   parameter int unsigned OutWidth       = 32,
   parameter int unsigned DecimWidth     = 16,
   parameter int unsigned TimestampWidth = 64
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   waveform_decimator_if.slave   in_i,
   waveform_decimator_if.master  out_o,
   input  logic [DecimWidth-1:0] decim_factor_i,
   input  logic [4:0]            shift_i,
   input  logic                  sat_clear_i,
   output logic [Channels-1:0]   sat_flags_o
);
   localparam int unsigned AccWidth = SampleWidth + DecimWidth;
   localparam int unsigned CmpWidth = (AccWidth > OutWidth) ? AccWidth : OutWidth;
   localparam logic signed [CmpWidth-1:0] SatMax =
      {{(CmpWidth - OutWidth + 1){1'b0}}, {(OutWidth - 1){1'b1}}};
   localparam logic signed [CmpWidth-1:0] SatMin = ~SatMax;

   typedef logic signed [AccWidth-1:0] acc_t;

   logic [DecimWidth-1:0]         cnt_q, cnt_d, n_act_q, n_act_d, n_eff, n_cur;
   acc_t                          acc_q [Channels];
   acc_t                          acc_d [Channels];
   acc_t                          sample [Channels];
   acc_t                          sum [Channels];
   logic signed [CmpWidth-1:0]    scaled [Channels];
   logic [OutWidth-1:0]           res [Channels];
   logic [7:0]                    trig_acc_q, trig_acc_d, trig_fin;
   logic [TimestampWidth-1:0]     ts_hold_q, ts_hold_d;
   logic [Channels*OutWidth-1:0]  out_data_q, out_data_d;
   logic                          out_valid_q, out_valid_d;
   logic [7:0]                    out_trig_q, out_trig_d;
   logic [TimestampWidth-1:0]     out_ts_q, out_ts_d;
   logic [Channels-1:0]           sat_q, sat_d, sat_hit;
   logic                          win_start, last;

   // The factor is only trusted from decim_factor_i on the window's first sample.
   always_comb begin
      n_eff     = (decim_factor_i == '0) ? DecimWidth'(1) : decim_factor_i;
      win_start = (cnt_q == '0);
      n_cur     = win_start ? n_eff : n_act_q;
      last      = in_i.valid && (cnt_q == n_cur - DecimWidth'(1));
      trig_fin  = win_start ? in_i.triggers : (trig_acc_q | in_i.triggers);
      sat_hit   = '0;
      for (int k = 0; k < int'(Channels); k++) begin
         sample[k] = acc_t'($signed(in_i.data[k*SampleWidth +: SampleWidth]));
         sum[k]    = win_start ? sample[k] : acc_q[k] + sample[k];
         if (32'(shift_i) >= AccWidth) begin
            scaled[k] = {CmpWidth{sum[k][AccWidth-1]}};
         end else begin
            scaled[k] = CmpWidth'(sum[k] >>> shift_i);
         end
         if (scaled[k] > SatMax) begin
            res[k]     = OutWidth'(SatMax);
            sat_hit[k] = 1'b1;
         end else if (scaled[k] < SatMin) begin
            res[k]     = OutWidth'(SatMin);
            sat_hit[k] = 1'b1;
         end else begin
            res[k] = OutWidth'(scaled[k]);
         end
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      n_act_d     = n_act_q;
      acc_d       = acc_q;
      trig_acc_d  = trig_acc_q;
      ts_hold_d   = ts_hold_q;
      out_data_d  = out_data_q;
      out_trig_d  = out_trig_q;
      out_ts_d    = out_ts_q;
      out_valid_d = 1'b0;
      sat_d       = sat_clear_i ? '0 : sat_q;
      if (in_i.valid) begin
         acc_d      = sum;
         trig_acc_d = trig_fin;
         if (win_start) begin
            ts_hold_d = in_i.timestamp;
            n_act_d   = n_eff;
         end
         if (last) begin
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_trig_d  = trig_fin;
            out_ts_d    = win_start ? in_i.timestamp : ts_hold_q;
            sat_d       = sat_d | sat_hit;
            for (int k = 0; k < int'(Channels); k++) begin
               out_data_d[k*OutWidth +: OutWidth] = res[k];
            end
         end else begin
            cnt_d = cnt_q + DecimWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q       <= '0;
         n_act_q     <= DecimWidth'(1);
         trig_acc_q  <= '0;
         ts_hold_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_trig_q  <= '0;
         out_ts_q    <= '0;
         sat_q       <= '0;
         for (int k = 0; k < int'(Channels); k++) begin
            acc_q[k] <= '0;
         end
      end else begin
         cnt_q       <= cnt_d;
         n_act_q     <= n_act_d;
         trig_acc_q  <= trig_acc_d;
         ts_hold_q   <= ts_hold_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_trig_q  <= out_trig_d;
         out_ts_q    <= out_ts_d;
         sat_q       <= sat_d;
         for (int k = 0; k < int'(Channels); k++) begin
            acc_q[k] <= acc_d[k];
         end
      end
   end

   assign out_o.data      = out_data_q;
   assign out_o.valid     = out_valid_q;
   assign out_o.triggers  = out_trig_q;
   assign out_o.timestamp = out_ts_q;
   assign sat_flags_o     = sat_q;
endmodule

// File: tb/tb_waveform_decimator.sv
// Scoreboard bench: two decimators (32- and 16-bit outputs) share one input stream and are
// checked against a window-list reference model.
module tb_waveform_decimator;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] decim = 16'd1;
   logic [4:0]  shift = 5'd0;
   logic        sat_clear = 1'b0;
   logic [3:0]  flags32, flags16;

   always #5 clk = ~clk;

   waveform_decimator_if #(.DataWidth(64),  .TimestampWidth(64)) in_if ();
   waveform_decimator_if #(.DataWidth(128), .TimestampWidth(64)) o32_if ();
   waveform_decimator_if #(.DataWidth(64),  .TimestampWidth(64)) o16_if ();

   waveform_decimator #(.OutWidth(32)) u_dut32 (
      .clk_i          (clk),
      .reset_i        (reset),
      .in_i           (in_if),
      .out_o          (o32_if),
      .decim_factor_i (decim),
      .shift_i        (shift),
      .sat_clear_i    (sat_clear),
      .sat_flags_o    (flags32)
   );

   waveform_decimator #(.OutWidth(16)) u_dut16 (
      .clk_i          (clk),
      .reset_i        (reset),
      .in_i           (in_if),
      .out_o          (o16_if),
      .decim_factor_i (decim),
      .shift_i        (shift),
      .sat_clear_i    (sat_clear),
      .sat_flags_o    (flags16)
   );

   typedef struct {
      logic [127:0] d32;
      logic [63:0]  d16;
      logic [7:0]   trig;
      logic [63:0]  ts;
   } beat_t;

   beat_t       pend_q[$];
   beat_t       exp_q[$];
   beat_t       held;
   logic [3:0]  fl32_exp = '0, fl16_exp = '0, fl32_nxt, fl16_nxt;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;

   logic [63:0] win_d[$];
   logic [7:0]  win_trig;
   logic [63:0] win_ts;
   int          win_n;
   logic [63:0] ts_ctr = 64'h0123_4567_0000_0000;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic longint clamp(input longint v, input int w, output bit hit);
      longint mx = (64'sd1 <<< (w - 1)) - 1;
      longint mn = -mx - 1;
      hit = 1'b0;
      if (v > mx) begin
         hit = 1'b1;
         return mx;
      end
      if (v < mn) begin
         hit = 1'b1;
         return mn;
      end
      return v;
   endfunction

   // Reference: collect the window's samples, then average them in one go at window close.
   task automatic model_accept(input logic [63:0] d, input logic [7:0] tg, input logic [63:0] ts);
      beat_t  b;
      longint s, r, c;
      bit     hit;
      if (win_d.size() == 0) begin
         win_n    = (decim == 16'd0) ? 1 : int'(decim);
         win_trig = 8'h00;
         win_ts   = ts;
      end
      win_d.push_back(d);
      win_trig |= tg;
      if (win_d.size() == win_n) begin
         b.trig = win_trig;
         b.ts   = win_ts;
         for (int k = 0; k < 4; k++) begin
            s = 0;
            foreach (win_d[i]) s += longint'($signed(win_d[i][k*16 +: 16]));
            r = s >>> shift;
            c = clamp(r, 32, hit);
            b.d32[k*32 +: 32] = c[31:0];
            if (hit) fl32_nxt[k] = 1'b1;
            c = clamp(r, 16, hit);
            b.d16[k*16 +: 16] = c[15:0];
            if (hit) fl16_nxt[k] = 1'b1;
         end
         pend_q.push_back(b);
         win_d.delete();
      end
   endtask

   task automatic cycle(input bit v, input logic [63:0] d, input logic [7:0] tg, input bit clr);
      in_if.valid     = v;
      in_if.data      = d;
      in_if.triggers  = tg;
      in_if.timestamp = ts_ctr;
      sat_clear       = clr;
      fl32_nxt = clr ? 4'h0 : fl32_exp;
      fl16_nxt = clr ? 4'h0 : fl16_exp;
      if (reset) begin
         win_d.delete();
         fl32_nxt = 4'h0;
         fl16_nxt = 4'h0;
      end else if (v) begin
         model_accept(d, tg, ts_ctr);
      end
      ts_ctr += 64'($urandom_range(1, 3));
      @(posedge clk);
      #1;
      fl32_exp = fl32_nxt;
      fl16_exp = fl16_nxt;
      while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
      if (reset) held = '{default: '0};
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] setch(input logic [63:0] d, input int k, input logic [15:0] v);
      logic [63:0] r = d;
      r[k*16 +: 16] = v;
      return r;
   endfunction

   initial begin
      beat_t b;
      bit    ev;
      wait (mon_en);
      forever begin
         @(negedge clk);
         ev = (exp_q.size() > 0);
         check("valid32", 128'(o32_if.valid), 128'(ev));
         check("valid16", 128'(o16_if.valid), 128'(ev));
         if (ev && o32_if.valid) begin
            b    = exp_q.pop_front();
            held = b;
         end else if (ev) begin
            void'(exp_q.pop_front());
         end
         check("data32", o32_if.data, held.d32);
         check("data16", 128'(o16_if.data), 128'(held.d16));
         check("trig", 128'(o32_if.triggers), 128'(held.trig));
         check("ts", 128'(o32_if.timestamp), 128'(held.ts));
         check("flags32", 128'(flags32), 128'(fl32_exp));
         check("flags16", 128'(flags16), 128'(fl16_exp));
      end
   end

   initial begin
      int vals[4];
      held = '{default: '0};
      in_if.valid = 1'b0;
      in_if.data = '0;
      in_if.triggers = '0;
      in_if.timestamp = '0;
      cycle(1'b1, rnd64(), 8'hff, 1'b0);
      cycle(1'b1, rnd64(), 8'hff, 1'b0);
      mon_en = 1'b1;
      reset  = 1'b0;

      // Passthrough
      decim = 16'd1;
      shift = 5'd0;
      vals = '{5, -3, 7, 0};
      for (int i = 0; i < 3; i++) cycle(1'b1, setch(rnd64(), 0, 16'(vals[i])), 8'h00, 1'b0);
      cycle(1'b0, rnd64(), 8'h00, 1'b0);

      // Averaging with gaps
      decim = 16'd4;
      shift = 5'd2;
      vals = '{1, 2, 3, 6};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, setch(rnd64(), 1, 16'(vals[i])), 8'h00, 1'b0);
         cycle(1'b0, rnd64(), 8'h00, 1'b0);
         cycle(1'b0, rnd64(), 8'h00, 1'b0);
      end

      // Saturation, then clear
      shift = 5'd0;
      for (int i = 0; i < 4; i++) cycle(1'b1, 64'h0000_0000_0000_7fff, 8'h00, 1'b0);
      cycle(1'b0, '0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 64'h0000_0000_0000_8000, 8'h00, 1'b0);
      cycle(1'b0, '0, 8'h00, 1'b0);
      cycle(1'b0, '0, 8'h00, 1'b1);
      cycle(1'b0, '0, 8'h00, 1'b0);

      // Trigger capture and hold
      decim = 16'd8;
      shift = 5'd3;
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, rnd64(), (i == 2) ? 8'h08 : 8'h00, 1'b0);
         if (i == 7) for (int j = 0; j < 3; j++) cycle(1'b0, rnd64(), 8'h00, 1'b0);
      end

      // Mid-window factor change
      decim = 16'd4;
      shift = 5'd1;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) decim = 16'd2;
         cycle(1'b1, rnd64(), 8'(i), 1'b0);
      end
      cycle(1'b0, rnd64(), 8'h00, 1'b0);

      // Reset mid-window
      decim = 16'd4;
      for (int i = 0; i < 3; i++) cycle(1'b1, rnd64(), 8'h40, 1'b0);
      reset = 1'b1;
      cycle(1'b1, rnd64(), 8'h20, 1'b0);
      reset = 1'b0;
      cycle(1'b0, rnd64(), 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, rnd64(), 8'h01, 1'b0);
      cycle(1'b0, rnd64(), 8'h00, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 39) == 0) decim = 16'($urandom_range(0, 5));
         shift = 5'($urandom_range(0, 31));
         cycle($urandom_range(0, 3) != 0, rnd64(),
               ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00,
               $urandom_range(0, 15) == 0);
      end

      for (int i = 0; i < 4; i++) cycle(1'b0, rnd64(), 8'h00, 1'b0);
      check("drain", 128'(exp_q.size() + pend_q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
